// File: rtl/sdram_rd_pkg.sv
// Shared types and sizing helpers for the SDRAM frame read path.
package sdram_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } rd_state_t;

  localparam int DEF_ADDR_W      = 21;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_BURST_LEN   = 8;
  localparam int DEF_FRAME_WORDS = 307200;
  localparam int DEF_FIFO_DEPTH  = 32;

  // Burst counter must hold FRAME_WORDS/BURST_LEN itself, not just count below it.
  function automatic int bcnt_w(input int frame_words, input int burst_len);
    return $clog2(frame_words / burst_len + 1);
  endfunction

  function automatic int fcnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/frame_rd_fifo.sv
// First-word-fall-through FIFO with a registered head word; exposes fill count.
module frame_rd_fifo import sdram_rd_pkg::*; #(
  parameter int W     = DEF_DATA_W + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int CW    = fcnt_w(DEPTH)
) (
  input  logic          I_clk,
  input  logic          I_rst_n,
  input  logic          I_wr_en,
  input  logic [W-1:0]  I_wr_data,
  input  logic          I_rd_en,
  output logic [W-1:0]  O_rd_data,
  output logic          O_rd_valid,
  output logic [CW-1:0] O_count,
  output logic          O_ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_vld;
  logic [W-1:0]  r_data;

  logic          w_pop, w_push, w_full, w_bypass;
  logic [AW-1:0] w_rptr_nxt;
  logic [CW-1:0] w_count_nxt;

  assign w_pop       = r_vld & I_rd_en;
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_push      = I_wr_en & (~w_full | w_pop);
  assign w_rptr_nxt  = r_rptr + AW'(w_pop);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  // Write lands in the slot that becomes the head: forward it straight to the output.
  assign w_bypass    = w_push & (r_wptr == w_rptr_nxt);

  assign O_rd_data  = r_data;
  assign O_rd_valid = r_vld;
  assign O_count    = r_count;
  assign O_ovf      = I_wr_en & w_full & ~w_pop;

  always_ff @(posedge I_clk) begin
    if (w_push) r_mem[r_wptr] <= I_wr_data;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_push);
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_vld   <= (w_count_nxt != '0);
      if (w_bypass)                 r_data <= I_wr_data;
      else if (w_count_nxt != '0)   r_data <= r_mem[w_rptr_nxt];
    end
  end

endmodule

// File: rtl/sdram_frame_reader.sv
// Frame read master: issues fixed-length SDRAM read bursts and streams the data out.
module sdram_frame_reader import sdram_rd_pkg::*; #(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_frame_start,
  input  logic [ADDR_W-1:0] I_frame_base,
  output logic              O_sdrc_rd_n,
  output logic [ADDR_W-1:0] O_sdrc_addr,
  input  logic              I_sdrc_busy_n,
  input  logic              I_sdrc_rd_valid,
  input  logic [DATA_W-1:0] I_sdrc_data,
  output logic [DATA_W-1:0] O_data,
  output logic              O_sof,
  output logic              O_valid,
  input  logic              I_ready,
  output logic              O_busy,
  output logic              O_frame_done,
  output logic              O_frame_drop,
  output logic              O_err
);

  localparam int NBURST = FRAME_WORDS / BURST_LEN;
  localparam int BCW    = bcnt_w(FRAME_WORDS, BURST_LEN);
  localparam int CW     = fcnt_w(FIFO_DEPTH);
  localparam int BW     = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] SPACE = CW'(FIFO_DEPTH - BURST_LEN);

  rd_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [BCW-1:0]    r_bursts;
  logic [BW-1:0]     r_beat;
  logic              r_sof, r_rd_n, r_busy, r_done, r_drop, r_err;

  logic              w_req_fire, w_last_beat, w_fifo_wr, w_ovf;
  logic [CW-1:0]     w_count;
  logic [DATA_W:0]   w_fifo_dout;

  assign w_fifo_wr = (r_state == ST_WAIT) & I_sdrc_rd_valid;

  frame_rd_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .I_wr_en    (w_fifo_wr),
    .I_wr_data  ({r_sof, I_sdrc_data}),
    .I_rd_en    (I_ready),
    .O_rd_data  (w_fifo_dout),
    .O_rd_valid (O_valid),
    .O_count    (w_count),
    .O_ovf      (w_ovf)
  );

  assign O_data       = w_fifo_dout[DATA_W-1:0];
  assign O_sof        = w_fifo_dout[DATA_W];
  assign O_sdrc_rd_n  = r_rd_n;
  assign O_sdrc_addr  = r_addr;
  assign O_busy       = r_busy;
  assign O_frame_done = r_done;
  assign O_frame_drop = r_drop;
  assign O_err        = r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_req_fire  = 1'b0;
    w_last_beat = 1'b0;
    case (r_state)
      ST_IDLE: if (I_frame_start) w_state_nxt = ST_REQ;
      // Only ask for a burst when it is guaranteed to fit.
      ST_REQ: if (I_sdrc_busy_n && (w_count <= SPACE)) begin
        w_req_fire  = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: if (I_sdrc_rd_valid && (r_beat == BW'(BURST_LEN - 1))) begin
        w_last_beat = 1'b1;
        w_state_nxt = (r_bursts == BCW'(1)) ? ST_IDLE : ST_REQ;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_bursts <= '0;
      r_beat   <= '0;
      r_sof    <= 1'b0;
      r_rd_n   <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_drop   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_rd_n  <= ~w_req_fire;
      r_done  <= w_last_beat & (r_bursts == BCW'(1));
      r_drop  <= I_frame_start & (r_state != ST_IDLE);
      r_err   <= r_err | (I_sdrc_rd_valid & (r_state != ST_WAIT)) | w_ovf;
      if (r_state == ST_IDLE && I_frame_start) begin
        r_addr   <= I_frame_base;
        r_bursts <= BCW'(NBURST);
        r_sof    <= 1'b1;
      end
      if (w_req_fire) r_beat <= '0;
      if (w_fifo_wr) begin
        r_sof  <= 1'b0;
        r_beat <= r_beat + BW'(1);
      end
      if (w_last_beat) begin
        r_addr   <= r_addr + ADDR_W'(BURST_LEN);
        r_bursts <= r_bursts - BCW'(1);
      end
    end
  end

endmodule
